// File: rtl/mdu.sv
// ----------------------------------------------------------------------------
// mdu -- multi-cycle multiply/divide unit for the EX stage.
//
// Executes MULT/MULTU/DIV/DIVU into the architectural HI/LO registers and
// services MTHI/MTLO writes. While a multiply or divide is in flight, busy is
// high so the hazard unit can stall MFHI/MFLO and further MD ops. HI/LO only
// change on the commit edge, which is marked by a one-cycle done pulse.
//
// Optional feature macro: MDU_MADD_EN
//   defined   -> md_op 110 MADD / 111 MSUB accumulate into {HI,LO}
//   undefined -> md_op 110/111 requests are ignored
//
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU (and MADD/MSUB), 1..15
//   DIV_CYCLES   busy cycles for DIV/DIVU, 1..15
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   one-cycle op request, only honoured while idle
//   md_op  in   3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                   100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
//   A      in   32  rs operand (dividend / multiplicand / MT source)
//   B      in   32  rt operand (divisor / multiplier)
//   busy   out  1   high while a MUL/DIV is in flight
//   done   out  1   one-cycle pulse following the HI/LO commit edge
//   HI     out  32  architectural HI register
//   LO     out  32  architectural LO register
// ----------------------------------------------------------------------------
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MADD  = 3'b110,
        OP_MSUB  = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    md_op_t      op_q;
    logic [31:0] a_q, b_q;

    logic        launch_mul, launch_div;
    logic        commit;
    md_op_t      op_in;

    assign op_in = md_op_t'(md_op);

    // Request decode; only meaningful while idle.
    always_comb begin
        launch_mul = 1'b0;
        launch_div = 1'b0;
        if (start && state == IDLE) begin
            unique case (op_in)
                OP_MULT, OP_MULTU: launch_mul = 1'b1;
`ifdef MDU_MADD_EN
                OP_MADD, OP_MSUB:  launch_mul = 1'b1;
`endif
                OP_DIV, OP_DIVU:   launch_div = 1'b1;
                default:           ;
            endcase
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (launch_mul)      state_next = MUL;
                else if (launch_div) state_next = DIV;
            end
            MUL, DIV: begin
                if (cnt == 4'd0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy   = (state != IDLE);
        commit = (state != IDLE) && (cnt == 4'd0);
    end

    // ---------------- Arithmetic on latched operands ----------------
    logic [63:0] prod_s, prod_u;
    logic        div_signed;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
    logic [63:0] result;

    always_comb begin
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};

        // Signed and unsigned divide share one magnitude divider; signs are
        // reapplied afterwards (quotient truncates to zero, remainder follows
        // the dividend). 0x80000000 / -1 falls out as 0x80000000 rem 0.
        div_signed = (op_q == OP_DIV);
        a_mag  = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
        b_mag  = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
        b_safe = (b_q == '0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - q_mag) : q_mag;
        rem    = (div_signed && a_q[31]) ? (32'd0 - r_mag) : r_mag;

        unique case (op_q)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV, OP_DIVU: begin
                if (b_q == '0) result = {a_q, 32'hFFFF_FFFF};
                else           result = {rem, quot};
            end
`ifdef MDU_MADD_EN
            // Accumulate base is the live {HI,LO} at the commit edge.
            OP_MADD:  result = {HI, LO} + prod_s;
            OP_MSUB:  result = {HI, LO} - prod_s;
`endif
            default:  result = {HI, LO};
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            op_q <= OP_MULT;
            a_q  <= '0;
            b_q  <= '0;
            done <= 1'b0;
            HI   <= '0;
            LO   <= '0;
        end else begin
            done <= commit;
            if (launch_mul || launch_div) begin
                op_q <= op_in;
                a_q  <= A;
                b_q  <= B;
                cnt  <= launch_mul ? 4'(MULT_CYCLES - 1) : 4'(DIV_CYCLES - 1);
            end else if (busy && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (commit) begin
                HI <= result[63:32];
                LO <= result[31:0];
            end else if (start && state == IDLE) begin
                if (op_in == OP_MTHI) HI <= A;
                if (op_in == OP_MTLO) LO <= A;
            end
        end
    end

endmodule
